// File: rtl/obstacle_pkg.sv
// Shared types and constants for the obstacle field.
package obstacle_pkg;

   localparam int SCREEN_W_DEF = 640;
   localparam int GROUND_Y_DEF = 400;

   // Screen coordinate, wide enough for a 1024-pixel axis.
   typedef logic [9:0] coord_t;

   // Feedback taps 16,14,13,11 expressed as state bits 15,13,12,10.
   localparam logic [15:0] LFSR_TAPS = 16'hB400;

   // Saturation ceiling for the spawn gap counter.
   localparam coord_t GAP_MAX = 10'd1023;

endpackage

// File: rtl/lfsr16.sv
// 16-bit Fibonacci LFSR. Free-running every clock, loads SEED on reset.
module lfsr16
   import obstacle_pkg::*;
#(
   parameter logic [15:0] SEED = 16'hACE1
) (
   input  logic        clk,
   input  logic        rst,
   output logic [15:0] state
);

   // Shift left, feeding the XOR of the tapped bits into bit 0.
   always_ff @(posedge clk) begin
      if (rst) state <= SEED;
      else     state <= {state[14:0], ^(state & LFSR_TAPS)};
   end

endmodule

// File: rtl/obstacle_field.sv
// Scrolling obstacle field: a fixed set of slots moving right-to-left,
// spawning at pseudo-random spacing and retiring off the left edge.
// Optional collision detection is built when OBSTACLE_FIELD_HIT_EN is defined;
// otherwise hit is tied low and the player box inputs are ignored.
// tick is a one-cycle frame strobe with no back-pressure: every cycle with
// tick=1 and Stop=0 advances the field once; there is no ready signal.
module obstacle_field
   import obstacle_pkg::*;
#(
   parameter int          N_OBST   = 3,
   parameter int          SCREEN_W = SCREEN_W_DEF,
   parameter int          GROUND_Y = GROUND_Y_DEF,
   parameter int          OBJ_W    = 15,
   parameter int          OBJ_H    = 33,
   parameter int          STEP     = 5,
   parameter int          MIN_GAP  = 160,
   parameter logic [15:0] SEED     = 16'hACE1
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   tick,
   input  logic                   Stop,
   input  logic [2:0]             speed,
   input  logic [9:0]             player_x,
   input  logic [9:0]             player_y,
   input  logic [9:0]             player_w,
   input  logic [9:0]             player_h,
   output logic [N_OBST*10-1:0]   Point_X,
   output logic [N_OBST-1:0]      active,
   output logic [9:0]             Point_Y,
   output logic [9:0]             Width,
   output logic [9:0]             Heigh,
   output logic                   passed,
   output logic                   hit
);

   localparam coord_t OBJ_Y = coord_t'(GROUND_Y - OBJ_H);

   logic [15:0]       lfsr;
   coord_t            x_q [N_OBST];
   logic [N_OBST-1:0] act_q;
   coord_t            gap_q;
   coord_t            thr_q;
   logic              passed_q;

   logic              adv;
   coord_t            step;
   coord_t            x_nxt [N_OBST];
   logic [N_OBST-1:0] act_nxt;
   logic              retire_any;
   logic [10:0]       gap_sum;
   coord_t            gap_sat;
   coord_t            gap_nxt;
   coord_t            thr_nxt;
   logic [N_OBST-1:0] spawn_oh;
   logic              free_found;
   logic              spawn;
   logic              unused_lfsr;

   lfsr16 #(.SEED(SEED)) u_lfsr (
      .clk   (clk),
      .rst   (rst),
      .state (lfsr)
   );

   // Only the low seven bits feed the spawn spacing.
   assign unused_lfsr = ^lfsr[15:7];

   // Next-state of every slot, the gap counter and the spawn decision.
   always_comb begin
      adv        = tick & ~Stop;
      step       = coord_t'(STEP) + coord_t'(speed);
      retire_any = 1'b0;
      act_nxt    = act_q;
      for (int i = 0; i < N_OBST; i++) begin
         x_nxt[i] = x_q[i];
         if (act_q[i]) begin
            if (x_q[i] < step) begin
               act_nxt[i] = 1'b0;
               x_nxt[i]   = coord_t'(SCREEN_W);
               retire_any = 1'b1;
            end else begin
               x_nxt[i] = x_q[i] - step;
            end
         end
      end
      gap_sum = {1'b0, gap_q} + {1'b0, step};
      gap_sat = gap_sum[10] ? GAP_MAX : gap_sum[9:0];
      // Free means inactive at cycle start, so a slot retiring now is excluded.
      free_found = 1'b0;
      spawn_oh   = '0;
      for (int i = 0; i < N_OBST; i++) begin
         if (!act_q[i] && !free_found) begin
            free_found  = 1'b1;
            spawn_oh[i] = 1'b1;
         end
      end
      spawn   = free_found && (gap_sat >= thr_q);
      gap_nxt = spawn ? '0 : gap_sat;
      thr_nxt = spawn ? coord_t'(MIN_GAP) + coord_t'(lfsr[6:0]) : thr_q;
      for (int i = 0; i < N_OBST; i++) begin
         if (spawn && spawn_oh[i]) begin
            act_nxt[i] = 1'b1;
            x_nxt[i]   = coord_t'(SCREEN_W);
         end
      end
   end

   // Field state advances only on unfrozen ticks; passed pulses for one cycle.
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < N_OBST; i++) x_q[i] <= coord_t'(SCREEN_W);
         act_q    <= '0;
         gap_q    <= '0;
         thr_q    <= coord_t'(MIN_GAP);
         passed_q <= 1'b0;
      end else begin
         passed_q <= adv & retire_any;
         if (adv) begin
            for (int i = 0; i < N_OBST; i++) x_q[i] <= x_nxt[i];
            act_q <= act_nxt;
            gap_q <= gap_nxt;
            thr_q <= thr_nxt;
         end
      end
   end

   // Pack slot X coordinates, slot i at bits [10i+9:10i].
   always_comb begin
      Point_X = '0;
      for (int i = 0; i < N_OBST; i++) Point_X[10*i +: 10] = x_q[i];
   end

   assign active  = act_q;
   assign passed  = passed_q;
   assign Point_Y = OBJ_Y;
   assign Width   = coord_t'(OBJ_W);
   assign Heigh   = coord_t'(OBJ_H);

`ifdef OBSTACLE_FIELD_HIT_EN
   logic [N_OBST-1:0] overlap;
   logic              hit_q;

   // Strict box overlap of each active slot against the player, 11-bit sums.
   always_comb begin
      overlap = '0;
      for (int i = 0; i < N_OBST; i++) begin
         overlap[i] = act_q[i]
            && ({1'b0, x_q[i]}   < ({1'b0, player_x} + {1'b0, player_w}))
            && ({1'b0, player_x} < ({1'b0, x_q[i]}   + 11'(OBJ_W)))
            && ({1'b0, OBJ_Y}    < ({1'b0, player_y} + {1'b0, player_h}))
            && ({1'b0, player_y} < ({1'b0, OBJ_Y}    + 11'(OBJ_H)));
      end
   end

   // Collision flag latches and holds until reset.
   always_ff @(posedge clk) begin
      if (rst) hit_q <= 1'b0;
      else     hit_q <= hit_q | (|overlap);
   end

   assign hit = hit_q;
`else
   logic unused_player;
   assign unused_player = ^{player_x, player_y, player_w, player_h};
   assign hit = 1'b0;
`endif

endmodule

// File: doc/obstacle_field.md
OBSTACLE_FIELD -- requirements
Module: obstacle_field

Interface
REQ-001 SHALL have parameter N_OBST, default 3, number of obstacle slots (1..8).
REQ-002 SHALL have parameter SCREEN_W, default 640, spawn X coordinate.
REQ-003 SHALL have parameter GROUND_Y, default 400, ground line Y.
REQ-004 SHALL have parameter OBJ_W, default 15, obstacle width; OBJ_H, default 33, obstacle height.
REQ-005 SHALL have parameter STEP, default 5, base pixels moved per tick.
REQ-006 SHALL have parameter MIN_GAP, default 160, minimum pixels travelled between spawns.
REQ-007 SHALL have parameter SEED, default 16'hACE1, LFSR reset value (nonzero).
REQ-008 SHALL have ports: clk in 1 system clock; rst in 1 reset, synchronous, active-high.
REQ-009 SHALL have ports: tick in 1 frame-advance strobe; Stop in 1 freeze motion; speed in 3 added to STEP.
REQ-010 SHALL have ports: player_x, player_y, player_w, player_h in 10 each, player bounding box.
REQ-011 SHALL have ports: Point_X out N_OBST*10 slot X (slot i at bits [10i+9:10i]); active out N_OBST slot valid mask.
REQ-012 SHALL have ports: Point_Y out 10; Width out 10; Heigh out 10; passed out 1 retire pulse; hit out 1 collision flag.

Function
REQ-013 SHALL drive Point_Y = GROUND_Y-OBJ_H, Width = OBJ_W, Heigh = OBJ_H as constants.
REQ-014 SHALL compute step = STEP + speed (10-bit, zero-extended), sampled on the tick cycle.
REQ-015 SHALL update state only on cycles with tick=1 and Stop=0 (except LFSR and hit); otherwise hold all slots, gap counter, threshold.
REQ-016 SHALL, per active slot on an advancing tick: if X < step, clear active, set X=SCREEN_W, count one retirement; else X = X-step (no unsigned underflow).
REQ-017 SHALL pulse passed high for exactly one cycle after any advancing tick retiring >=1 slot (multiple same-tick retirements = one pulse).
REQ-018 SHALL accumulate gap += step per advancing tick, saturating at 1023.
REQ-019 SHALL spawn when gap >= threshold and a free slot exists: lowest-index slot inactive at cycle start gets active=1, X=SCREEN_W; gap cleared to 0; threshold = MIN_GAP + lfsr[6:0].
REQ-020 SHALL NOT spawn into a slot retiring in the same tick; if no free slot, defer spawn (gap keeps saturating) until one frees.
REQ-021 SHALL spawn at most one obstacle per tick.
REQ-022 SHALL advance a 16-bit Fibonacci LFSR (taps 16,14,13,11) every clk cycle regardless of tick/Stop.
REQ-023 SHALL evaluate hit as registered OR over active slots of strict box overlap (ax<bx+bw, bx<ax+aw, same in Y), 1-cycle latency, sticky until rst.

Reset
REQ-024 SHALL on rst: all X=SCREEN_W, active=0, gap=0, threshold=MIN_GAP, passed=0, hit=0, LFSR=SEED.
REQ-025 SHALL have rst override tick in the same cycle, including mid-move or mid-spawn.

Configuration
REQ-026 SHALL, with OBSTACLE_FIELD_HIT_EN defined, implement REQ-023 collision logic.
REQ-027 SHALL, without OBSTACLE_FIELD_HIT_EN, tie hit to 0, ignore player_* ports, and synthesise no comparators.

Structure
REQ-028 SHALL place SCREEN_W/GROUND_Y defaults, coord_t (10-bit) typedef and LFSR tap constant in package obstacle_pkg.
REQ-029 SHALL instantiate sub-module lfsr16 (clk, rst, SEED parameter, 16-bit state out).

Verification
REQ-030 SHALL test: rst, then 32 ticks, speed=0 -> first spawn on tick 32 (gap 160), slot0 X=640, active=3'b001.
REQ-031 SHALL test: slot0 at X=3, step=5 -> next tick active[0]=0, X=640, passed one-cycle pulse.
REQ-032 SHALL test: Stop=1 for 10 ticks -> Point_X, active, gap unchanged; LFSR still advances.
REQ-033 SHALL test: all 3 slots active, gap saturates -> no spawn until a retirement, then spawn on following tick into freed lowest slot.
REQ-034 SHALL test: slot X=100, player box (95,370,20,40), HIT_EN -> hit=1 one cycle later, stays 1 after player moves away; rst clears.
REQ-035 SHALL test: speed=7 -> each advancing tick reduces X by 12; rst asserted with tick=1 -> reset values, no movement.
